// File: rtl/led_show_sched.sv
// ---------------------------------------------------------------------------
// led_show_sched
//
// Pattern scheduler for an LED show. A prescaler turns the system clock into
// pattern "steps". In manual mode the pattern select follows the switches; in
// auto mode it walks a playlist 0..LAST_MODE, spending DWELL steps on each
// entry. A push-button skips to the next playlist entry, and a pause input
// freezes all sequencing.
//
// Parameters
//   TICK_DIV  : clk cycles per pattern step
//   DWELL     : steps spent on each pattern in auto mode
//   LAST_MODE : highest pattern index in the auto playlist
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   sw_mode  in   3  manual pattern select (switches)
//   auto_en  in   1  1 = auto playlist, 0 = manual
//   pause    in   1  1 = freeze pattern sequencing
//   btn_next in   1  raw asynchronous push-button
//   mode     out  3  registered pattern select
//   step     out  1  one-cycle pulse per pattern step
//   state    out  2  FSM state: MANUAL=0, AUTO=1, PAUSE=2
// ---------------------------------------------------------------------------
module led_show_sched #(
   parameter int TICK_DIV  = 20000000,
   parameter int DWELL     = 8,
   parameter int LAST_MODE = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw_mode,
   input  logic       auto_en,
   input  logic       pause,
   input  logic       btn_next,
   output logic [2:0] mode,
   output logic       step,
   output logic [1:0] state
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);
   localparam logic [2:0]    LAST_IDX  = 3'(LAST_MODE);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_AUTO   = 2'd1,
      ST_PAUSE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [2:0]      idx_q, idx_d;
   logic [2:0]      mode_q, mode_d;
   logic            step_q, step_d;
   logic [2:0]      btn_sync_q, btn_sync_d;
   logic            btn_pulse_q, btn_pulse_d;

   // Next playlist entry, wrapping after the last pattern.
   function automatic logic [2:0] next_idx(input logic [2:0] cur);
      if (cur == LAST_IDX) begin
         next_idx = 3'd0;
      end else begin
         next_idx = cur + 3'd1;
      end
   endfunction

   // Next-state, counter and output computation.
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      dwell_d     = dwell_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      step_d      = 1'b0;
      // Two synchronizer stages plus a history flop; the edge pulse is
      // registered so the rest of the logic sees a clean one-cycle strobe.
      btn_sync_d  = {btn_sync_q[1:0], btn_next};
      btn_pulse_d = btn_sync_q[1] & ~btn_sync_q[2];

      if (pause) begin
         state_d = ST_PAUSE;
      end else if (auto_en) begin
         state_d = ST_AUTO;
      end else begin
         state_d = ST_MANUAL;
      end

      // The prescaler is frozen while paused and resumes where it stopped.
      if (state_q == ST_PAUSE) begin
         presc_d = presc_q;
      end else if (presc_q == PRESC_MAX) begin
         presc_d = {PW{1'b0}};
      end else begin
         presc_d = presc_q + PW'(1);
      end

      // step_q is high exactly in the step cycle, so it qualifies dwell
      // counting directly. A button pulse and a dwell wrap in the same cycle
      // share one advance. Button pulses outside AUTO are simply dropped.
      case (state_q)
         ST_MANUAL: begin
            if (state_d == ST_AUTO) begin
               idx_d   = 3'd0;
               dwell_d = {DW{1'b0}};
            end else begin
               idx_d   = idx_q;
               dwell_d = dwell_q;
            end
         end
         ST_AUTO: begin
            if (btn_pulse_q || (step_q && (dwell_q == DWELL_MAX))) begin
               idx_d   = next_idx(idx_q);
               dwell_d = {DW{1'b0}};
            end else if (step_q) begin
               dwell_d = dwell_q + DW'(1);
            end else begin
               dwell_d = dwell_q;
            end
         end
         default: begin
            idx_d   = idx_q;
            dwell_d = dwell_q;
         end
      endcase

      // mode is computed from the upcoming state so that it changes on the
      // same edge as the state transition.
      case (state_d)
         ST_MANUAL: mode_d = sw_mode;
         ST_AUTO:   mode_d = idx_d;
         default:   mode_d = mode_q;
      endcase

      // Registered step equals (prescaler at max && not paused) of the
      // cycle in which it is visible.
      if ((presc_d == PRESC_MAX) && (state_d != ST_PAUSE)) begin
         step_d = 1'b1;
      end else begin
         step_d = 1'b0;
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_MANUAL;
         presc_q     <= {PW{1'b0}};
         dwell_q     <= {DW{1'b0}};
         idx_q       <= 3'd0;
         mode_q      <= 3'd0;
         step_q      <= 1'b0;
         btn_sync_q  <= 3'd0;
         btn_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         dwell_q     <= dwell_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         step_q      <= step_d;
         btn_sync_q  <= btn_sync_d;
         btn_pulse_q <= btn_pulse_d;
      end
   end

   assign mode  = mode_q;
   assign step  = step_q;
   assign state = state_q;

endmodule

// File: doc/led_show_sched.md
LED_SHOW_SCHED -- requirements
Module: led_show_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 20000000: clk cycles per pattern step.
REQ-002 SHALL have parameter DWELL, default 8: steps spent on each pattern in auto mode.
REQ-003 SHALL have parameter LAST_MODE, default 6: highest pattern index in the auto playlist.
REQ-004 SHALL have port clk  in  1: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port sw_mode  in  3: manual pattern select from the switches.
REQ-007 SHALL have port auto_en  in  1: level; 1 = auto playlist, 0 = manual.
REQ-008 SHALL have port pause  in  1: level; 1 = freeze pattern sequencing.
REQ-009 SHALL have port btn_next  in  1: raw asynchronous push-button input.
REQ-010 SHALL have port mode  out  3: registered pattern select to the LED pattern generator.
REQ-011 SHALL have port step  out  1: one-cycle pulse per pattern step.
REQ-012 SHALL have port state  out  2: FSM state, MANUAL=0, AUTO=1, PAUSE=2.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; step SHALL be 1 for exactly the cycle in which the count equals TICK_DIV-1 and state is not PAUSE.
REQ-014 Prescaler SHALL hold its value while state is PAUSE and resume from that value on exit.
REQ-015 FSM transition priority SHALL be: pause=1 from any state -> PAUSE; else auto_en=1 -> AUTO; else -> MANUAL. All transitions take one clk.
REQ-016 In MANUAL, mode SHALL equal sw_mode registered, with 1-cycle latency; value 7 SHALL pass through unmodified.
REQ-017 On a MANUAL->AUTO transition, auto index SHALL load 0 and the dwell counter SHALL clear.
REQ-018 In AUTO, each step SHALL increment the dwell counter; when the counter equals DWELL-1 and step is high:
- dwell counter clears;
- auto index advances, with LAST_MODE -> 0 wrap.
REQ-019 In AUTO, mode SHALL equal the auto index.
REQ-020 btn_next SHALL pass a 2-flop synchronizer followed by a rising-edge detector. The detected pulse therefore occurs 3 clk after the input rise.
REQ-021 A detected btn_next pulse in AUTO SHALL advance the auto index by one (with wrap) and clear the dwell counter.
REQ-022 A detected btn_next pulse in the same cycle as a dwell wrap SHALL advance the auto index exactly once.
REQ-023 btn_next SHALL be ignored in MANUAL and PAUSE; an edge detected during PAUSE SHALL NOT be queued.
REQ-024 In PAUSE, mode SHALL hold its last value.
REQ-025 PAUSE->AUTO SHALL preserve the auto index and dwell counter.
REQ-026 PAUSE->MANUAL SHALL resume tracking sw_mode on the next cycle.
REQ-027 AUTO->MANUAL SHALL NOT clear the auto index; the index is reloaded only per REQ-017.
REQ-028 Counter widths SHALL hold TICK_DIV-1 and DWELL-1 without overflow; DWELL=1 SHALL advance on every step.

Reset
REQ-029 While rst_n=0, regardless of clk, the block SHALL force:
- mode=0, step=0, state=MANUAL;
- prescaler, dwell counter, auto index and synchronizer flops to 0.
REQ-030 After rst_n deasserts, the first step SHALL occur TICK_DIV cycles later.
REQ-031 Asserting rst_n mid-step or mid-dwell SHALL abort with no further step pulse.

Verification (TICK_DIV=4, DWELL=3, LAST_MODE=6)
REQ-032 Manual tracking: auto_en=0, sw_mode=5 -> mode=5 one cycle later; step pulses every 4 clk; sw_mode=7 -> mode=7.
REQ-033 Auto playlist: auto_en 0->1 -> state=1 and mode=0 next cycle; mode=1 after 3 steps (12 clk); sequence runs 0..6, then 0 after 84 clk total.
REQ-034 Pause: pause=1 while mode=3 with dwell=1 ->
- state=2, no step, mode stays 3;
- after pause=0, mode=4 after exactly 2 more steps.
REQ-035 Button: btn_next rise in AUTO at mode=2 -> mode=3 on the 4th clk after the rise; dwell restarts. A press timed to coincide with a dwell wrap -> single advance. A press in PAUSE -> no change after resume.
REQ-036 Async reset: rst_n=0 between clk edges during AUTO mode=5 -> mode=0, state=0, step=0 immediately; after release, first step after 4 clk.
